// File: rtl/strobe_div_pkg.sv
// Shared types and helpers for the multi-channel strobe divider.
package strobe_div_pkg;

    // Widest divisor the helper function handles; channel WIDTH must not exceed it.
    localparam int MAX_WIDTH = 32;

    // Width of the channel-select field: at least one bit, even for a single channel.
    function automatic int ch_width(input int num_ch);
        int w_s;
        if (num_ch > 1) begin
            w_s = $clog2(num_ch);
        end else begin
            w_s = 1;
        end
        return w_s;
    endfunction

    // Effective divisor: a programmed 0 behaves as 1 (strobe every enabled cycle).
    function automatic logic [MAX_WIDTH-1:0] eff_div(input logic [MAX_WIDTH-1:0] div);
        logic [MAX_WIDTH-1:0] d_s;
        if (div == {MAX_WIDTH{1'b0}}) begin
            d_s = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            d_s = div;
        end
        return d_s;
    endfunction

endpackage

// File: rtl/strobe_div_ch.sv
// One strobe channel: counter, active divisor, staged divisor and registered strobe.
module strobe_div_ch
    import strobe_div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             en,
    input  logic             sync,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_div,
    output logic             strobe,
    output logic             pending
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_r, div_r, pend_div_r;
    logic             pending_r, strobe_r;

    logic [WIDTH-1:0] cnt_s, div_s, pend_div_s, d_s;
    logic             pending_s, strobe_s, last_s, wrap_s;

    // Next-state: sync restarts the phase and applies staged divisors; otherwise count and hand over at wrap.
    always_comb begin
        d_s        = WIDTH'(eff_div(MAX_WIDTH'(div_r)));
        last_s     = (cnt_r == (d_s - ONE));
        wrap_s     = en & ~sync & last_s;
        cnt_s      = cnt_r;
        div_s      = div_r;
        pend_div_s = pend_div_r;
        pending_s  = pending_r;
        strobe_s   = 1'b0;
        if (sync) begin
            cnt_s     = ZERO;
            pending_s = 1'b0;
            // A same-cycle load can only arrive while nothing is staged, so it goes straight in.
            if (load_valid) begin
                div_s = load_div;
            end else if (pending_r) begin
                div_s = pend_div_r;
            end else begin
                div_s = div_r;
            end
        end else begin
            strobe_s = wrap_s;
            if (en) begin
                if (last_s) begin
                    cnt_s = ZERO;
                end else begin
                    cnt_s = cnt_r + ONE;
                end
            end else begin
                cnt_s = cnt_r;
            end
            // Hand-over uses the staged state as it was before this edge.
            if (wrap_s && pending_r) begin
                div_s     = pend_div_r;
                pending_s = 1'b0;
            end else begin
                div_s = div_r;
            end
            if (load_valid) begin
                pend_div_s = load_div;
                pending_s  = 1'b1;
            end else begin
                pend_div_s = pend_div_r;
            end
        end
    end

    // Channel state register with asynchronous reset to the default divisor.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_r      <= ZERO;
            div_r      <= RST_DIV;
            pend_div_r <= ZERO;
            pending_r  <= 1'b0;
            strobe_r   <= 1'b0;
        end else begin
            cnt_r      <= cnt_s;
            div_r      <= div_s;
            pend_div_r <= pend_div_s;
            pending_r  <= pending_s;
            strobe_r   <= strobe_s;
        end
    end

    assign strobe  = strobe_r;
    assign pending = pending_r;

endmodule

// File: rtl/multi_strobe_div.sv
// Multi-channel clock-enable strobe generator with a shared valid/ready divisor config port.
module multi_strobe_div
    import strobe_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CH-1:0]             i_en,
    input  logic                          i_sync,
    input  logic                          i_cfg_valid,
    output logic                          o_cfg_ready,
    input  logic [ch_width(NUM_CH)-1:0]   i_cfg_ch,
    input  logic [WIDTH-1:0]              i_cfg_div,
    output logic [NUM_CH-1:0]             o_strobe,
    output logic [NUM_CH-1:0]             o_pending
);

    localparam int CH_W = ch_width(NUM_CH);

    if ((DEFAULT_DIV < 1) || ((DEFAULT_DIV >> WIDTH) != 0) || (WIDTH < 1) || (WIDTH > MAX_WIDTH)
        || (NUM_CH < 1)) begin : g_param_check
        $error("multi_strobe_div: illegal parameters (DEFAULT_DIV out of 1..2**WIDTH-1, or bad WIDTH/NUM_CH)");
    end

    logic [NUM_CH-1:0] sel_s, load_s, pending_s;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        // An out-of-range channel index selects nothing, so it is accepted and dropped.
        assign sel_s[ch]  = (i_cfg_ch == CH_W'(ch));
        assign load_s[ch] = i_cfg_valid & sel_s[ch] & ~pending_s[ch];

        strobe_div_ch #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .en         (i_en[ch]),
            .sync       (i_sync),
            .load_valid (load_s[ch]),
            .load_div   (i_cfg_div),
            .strobe     (o_strobe[ch]),
            .pending    (pending_s[ch])
        );
    end

    // Ready only stalls when the addressed channel already has a divisor staged.
    assign o_cfg_ready = ~|(sel_s & pending_s);
    assign o_pending   = pending_s;

endmodule

// File: tb/tb_multi_strobe_div.sv
// Self-checking bench for multi_strobe_div: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_multi_strobe_div;

    localparam int NUM_CH = 5;
    localparam int WIDTH  = 16;
    localparam int DDIV   = 3;
    localparam int CH_W   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] en;
    logic              sync;
    logic              valid;
    logic              ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [WIDTH-1:0]  cfg_div;
    logic [NUM_CH-1:0] strobe;
    logic [NUM_CH-1:0] pend;

    int n_cmp = 0;
    int n_bad = 0;

    multi_strobe_div #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEFAULT_DIV(DDIV)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_sync      (sync),
        .i_cfg_valid (valid),
        .o_cfg_ready (ready),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_div   (cfg_div),
        .o_strobe    (strobe),
        .o_pending   (pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt  [NUM_CH];
    int m_div  [NUM_CH];
    int m_pdiv [NUM_CH];
    bit m_pend [NUM_CH];
    bit m_stb  [NUM_CH];

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_div[c] = DDIV; m_pdiv[c] = 0; m_pend[c] = 0; m_stb[c] = 0;
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NUM_CH) return 1'b1;
        return !m_pend[int'(cfg_ch)];
    endfunction

    function automatic logic [NUM_CH-1:0] model_vec(input bit sel_pend);
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = sel_pend ? m_pend[c] : m_stb[c];
        return v;
    endfunction

    // Predict the state after the coming clock edge from the inputs it will sample.
    task automatic model_step();
        bit xfer;
        int d;
        xfer = valid && model_ready() && (int'(cfg_ch) < NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            d = (m_div[c] == 0) ? 1 : m_div[c];
            if (sync) begin
                m_cnt[c] = 0;
                m_stb[c] = 0;
                if (xfer && int'(cfg_ch) == c) m_div[c] = int'(cfg_div);
                else if (m_pend[c])            m_div[c] = m_pdiv[c];
                m_pend[c] = 0;
            end else begin
                m_stb[c] = en[c] && (m_cnt[c] == d - 1);
                if (en[c]) m_cnt[c] = (m_cnt[c] + 1) % d;
                if (m_stb[c] && m_pend[c]) begin
                    m_div[c]  = m_pdiv[c];
                    m_pend[c] = 0;
                end
                if (xfer && int'(cfg_ch) == c) begin
                    m_pdiv[c] = int'(cfg_div);
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    // Compare process: check outputs on every falling edge, then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            check("model_strobe",  32'(strobe), 32'(model_vec(1'b0)));
            check("model_pending", 32'(pend),   32'(model_vec(1'b1)));
            check("model_ready",   32'(ready),  32'(model_ready()));
            if (!rst) model_step();
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cfg_write(input int ch, input int dv, output int stalls);
        bit done;
        stalls  = 0;
        done    = 0;
        valid   = 1'b1;
        cfg_ch  = CH_W'(ch);
        cfg_div = WIDTH'(dv);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (ready) done = 1;
            else       stalls++;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL cfg_write_timeout ch=%0d: ready stayed 0, required 1", ch);
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // After reset release with all channels enabled at the default divisor: strobes on edges 3, 6, 9.
    task automatic default_run();
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("dflt_strobe", 32'(strobe), (k % 3 == 0) ? 32'h1f : 32'h0);
            if (k == 1) begin
                check("dflt_pending", 32'(pend), 32'h0);
                check("dflt_ready",   32'(ready), 32'h1);
            end
        end
    endtask

    initial begin
        int st;
        bit cleared;
        rst = 1'b1; en = '0; sync = 1'b0; valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; en = 5'b11111;
        default_run();

        // Reprogram ch1 to 5 while its counter is at 1.
        @(posedge clk); #1;
        cfg_write(1, 5, st);
        check("ch1_pend_set", 32'(pend[1]), 32'h1);
        check("ch1_ready_lo", 32'(ready),   32'h0);
        @(posedge clk); #1;
        check("ch1_handover_strobe", 32'(strobe[1]), 32'h1);
        check("ch1_pend_clear",      32'(pend[1]),   32'h0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check("ch1_period5", 32'(strobe[1]), (k == 5 || k == 10) ? 32'h1 : 32'h0);
            check("ch0_period3", 32'(strobe[0]), (k % 3 == 0) ? 32'h1 : 32'h0);
        end

        // Back-to-back writes to ch1: the second stalls until the staged value is applied.
        cfg_write(1, 4, st);
        check("ch1_first_nostall", 32'(st), 32'd0);
        cfg_write(1, 6, st);
        check("ch1_second_stalls", 32'(st), 32'd4);
        check("ch1_second_pend",   32'(pend[1]), 32'h1);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            check("ch1_4then6", 32'(strobe[1]), (k == 3 || k == 9) ? 32'h1 : 32'h0);
        end

        // Divisor 0 clamps to 1: strobe held high while enabled.
        cfg_write(2, 0, st);
        cleared = 0;
        for (int i = 0; i < 10 && !cleared; i++) begin
            @(negedge clk);
            if (!pend[2]) cleared = 1;
        end
        if (!cleared) begin
            n_cmp++; n_bad++;
            $display("FAIL ch2_apply_timeout: pending stayed 1, required 0");
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("ch2_div0_high", 32'(strobe[2]), 32'h1);
        end
        cfg_write(2, 1, st);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("ch2_div1_high", 32'(strobe[2]), 32'h1);
        end
        en[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("ch2_disabled_low", 32'(strobe[2]), 32'h0);
        end
        en[2] = 1'b1;
        @(posedge clk); #1;
        check("ch2_resume_high", 32'(strobe[2]), 32'h1);

        // Stage ch3=7 on a disabled channel, stagger phases, then sync with a direct ch0 write.
        en[3] = 1'b0;
        cfg_write(3, 7, st);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            en = NUM_CH'($urandom) & 5'b10111;
        end
        check("ch3_pend_held", 32'(pend[3]), 32'h1);
        en = 5'b11111; sync = 1'b1; valid = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd2;
        @(posedge clk); #1;
        sync = 1'b0; valid = 1'b0;
        check("sync_strobe_zero",  32'(strobe), 32'h0);
        check("sync_pending_zero", 32'(pend),   32'h0);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            check("sync_ch0_d2", 32'(strobe[0]), (k % 2 == 0) ? 32'h1 : 32'h0);
            check("sync_ch3_d7", 32'(strobe[3]), (k == 7) ? 32'h1 : 32'h0);
            check("sync_ch4_d3", 32'(strobe[4]), (k % 3 == 0) ? 32'h1 : 32'h0);
        end

        // Random traffic: enables, writes (including out-of-range channels) and sync pulses.
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            en      = NUM_CH'($urandom);
            sync    = ($urandom_range(0, 19) == 0);
            valid   = ($urandom_range(0, 2) == 0);
            cfg_ch  = CH_W'($urandom_range(0, 7));
            cfg_div = WIDTH'($urandom_range(0, 7));
        end
        @(posedge clk); #1;
        en = 5'b11111; sync = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        cfg_ch = 3'd2; cfg_div = 16'd1; valid = 1'b1;
        @(posedge clk); #1;
        sync = 1'b0; valid = 1'b0; en = 5'b01111;

        // Asynchronous reset mid-period with ch4 holding a staged divisor.
        cfg_write(4, 5, st);
        check("ch4_pend_before_rst", 32'(pend[4]), 32'h1);
        @(posedge clk); #1;
        check("ch2_high_before_rst", 32'(strobe[2]), 32'h1);
        #2; rst = 1'b1;
        #1;
        check("async_rst_strobe",  32'(strobe), 32'h0);
        check("async_rst_pending", 32'(pend),   32'h0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; en = 5'b11111;
        default_run();

        // Out-of-range channel: accepted and discarded.
        valid = 1'b1; cfg_ch = 3'd5; cfg_div = 16'd9;
        #1;
        check("oor_ready", 32'(ready), 32'h1);
        @(posedge clk); #1;
        valid = 1'b0;
        check("oor_no_pend", 32'(pend),   32'h0);
        check("oor_k10",     32'(strobe), 32'h0);
        for (int k = 11; k <= 15; k++) begin
            @(posedge clk); #1;
            check("oor_period3", 32'(strobe), (k % 3 == 0) ? 32'h1f : 32'h0);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
